// File: rtl/pinball_score_ctrl.sv
// Pinball score controller.
// Four scoring requesters are captured into a pending register and
// serviced one at a time, round-robin. Each service adds that
// requester's point value to a saturating 16-bit score. A small game
// FSM (IDLE/PLAY/OVER) tracks the balls left in the current game.
module pinball_score_ctrl #(
  parameter int unsigned PV0   = 100,
  parameter int unsigned PV1   = 250,
  parameter int unsigned PV2   = 500,
  parameter int unsigned PV3   = 1000,
  parameter int unsigned BALLS = 3
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic        start,
  input  logic        drain,
  input  logic [3:0]  req,
  output logic [15:0] score,
  output logic [3:0]  grant,
  output logic [1:0]  balls_left,
  output logic [1:0]  state,
  output logic        missed
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] score_q;
  logic [3:0]  grant_q;
  logic [1:0]  balls_q;
  logic [3:0]  pend_q;
  logic [1:0]  rr_q;
  logic        missed_q;

  // Round-robin pick: first pending bit at rr, rr+1, ... (2-bit index wraps)
  logic       sel_vld;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!sel_vld && pend_q[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Point value of the selected requester
  logic [15:0] pts;
  always_comb begin
    pts = 16'd0;
    case (sel_idx)
      2'd0: pts = 16'(PV0);
      2'd1: pts = 16'(PV1);
      2'd2: pts = 16'(PV2);
      2'd3: pts = 16'(PV3);
      default: pts = 16'd0;
    endcase
  end

  // Saturating add: 17-bit sum, clamp on carry out
  logic [16:0] sum;
  logic [15:0] score_sat;
  always_comb begin
    sum       = {1'b0, score_q} + {1'b0, pts};
    score_sat = sum[16] ? 16'hFFFF : sum[15:0];
  end

  // Pending-register update: the granted bit is cleared, new hits set bits.
  // A hit on a bit that is already pending and not being serviced merges
  // into the existing request and is flagged as missed.
  logic [3:0] sel_oh;
  logic [3:0] pend_d;
  logic       miss_hit;
  always_comb begin
    sel_oh   = sel_vld ? (4'b0001 << sel_idx) : 4'b0000;
    pend_d   = (pend_q & ~sel_oh) | req;
    miss_hit = |(req & pend_q & ~sel_oh);
  end

  // Game FSM with registered outputs; reset overrides all inputs
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_q  <= S_IDLE;
      score_q  <= 16'd0;
      grant_q  <= 4'd0;
      balls_q  <= 2'd0;
      pend_q   <= 4'd0;
      rr_q     <= 2'd0;
      missed_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          grant_q <= 4'd0;
          if (start) begin
            state_q  <= S_PLAY;
            score_q  <= 16'd0;
            balls_q  <= 2'(BALLS);
            pend_q   <= 4'd0;
            rr_q     <= 2'd0;
            missed_q <= 1'b0;
          end
        end
        S_PLAY: begin
          grant_q <= sel_oh;
          if (sel_vld) begin
            score_q <= score_sat;
            rr_q    <= sel_idx + 2'd1;
          end
          if (miss_hit) missed_q <= 1'b1;
          // A drain abandons everything still pending, after this edge's add
          if (drain) begin
            pend_q <= 4'd0;
            if (balls_q > 2'd1) balls_q <= balls_q - 2'd1;
            else                state_q <= S_OVER;
          end else begin
            pend_q <= pend_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 4'd0;
        end
      endcase
    end
  end

  assign score      = score_q;
  assign grant      = grant_q;
  assign balls_left = balls_q;
  assign state      = state_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_pinball_score_ctrl.sv
// Bench for pinball_score_ctrl: directed scenarios with literal
// expectations, then randomized play, all tracked by a game-level model.
module tb_pinball_score_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        drain = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] score;
  logic [3:0]  grant;
  logic [1:0]  balls_left;
  logic [1:0]  state;
  logic        missed;

  always #10 clk = ~clk;

  pinball_score_ctrl dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .start         (start),
    .drain         (drain),
    .req           (req),
    .score         (score),
    .grant         (grant),
    .balls_left    (balls_left),
    .state         (state),
    .missed        (missed)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-level reference: a list of waiting hits, a pointer for fairness,
  // a plain integer score clamped at 65535.
  int       m_score = 0;
  int       m_balls = 0;
  int       m_state = 0;
  int       m_rr    = 0;
  bit       m_pend[4];
  logic [3:0] m_grant = 4'd0;
  bit       m_missed = 1'b0;
  int       pv[4] = '{100, 250, 500, 1000};

  always @(posedge clk) begin : model
    int sel;
    bit nxt[4];
    if (rst) begin
      m_score = 0; m_balls = 0; m_state = 0; m_rr = 0;
      m_grant = 4'd0; m_missed = 1'b0;
      for (int b = 0; b < 4; b++) m_pend[b] = 1'b0;
    end else if (m_state == 1) begin
      sel = -1;
      for (int k = 0; k < 4; k++)
        if (sel < 0 && m_pend[(m_rr + k) % 4]) sel = (m_rr + k) % 4;
      nxt = m_pend;
      m_grant = 4'd0;
      if (sel >= 0) begin
        m_score = m_score + pv[sel];
        if (m_score > 65535) m_score = 65535;
        nxt[sel] = 1'b0;
        m_grant  = 4'(1 << sel);
        m_rr     = (sel + 1) % 4;
      end
      for (int b = 0; b < 4; b++)
        if (req[b]) begin
          if (m_pend[b] && b != sel) m_missed = 1'b1;
          nxt[b] = 1'b1;
        end
      if (drain) begin
        for (int b = 0; b < 4; b++) nxt[b] = 1'b0;
        if (m_balls > 1) m_balls--;
        else m_state = 2;
      end
      m_pend = nxt;
    end else begin
      m_grant = 4'd0;
      if (m_state == 3) m_state = 0;
      else if (start) begin
        m_score = 0; m_balls = 3; m_state = 1; m_rr = 0; m_missed = 1'b0;
        for (int b = 0; b < 4; b++) m_pend[b] = 1'b0;
      end
    end
  end

  // Every cycle once reset has been applied: outputs must match the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score",  {16'd0, score},      m_score);
      chk("grant",  {28'd0, grant},      {28'd0, m_grant});
      chk("balls",  {30'd0, balls_left}, m_balls);
      chk("state",  {30'd0, state},      m_state);
      chk("missed", {31'd0, missed},     {31'd0, m_missed});
    end
  end

  // One clock: inputs applied at negedge, held across the posedge, cleared after
  task automatic cyc(input logic r, input logic s, input logic d, input logic [3:0] q);
    @(negedge clk);
    rst = r; start = s; drain = d; req = q;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; drain = 1'b0; req = 4'd0;
  endtask

  task automatic new_game();
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 4'hF);
    chk_en = 1'b1;
    chk("rst_state",  {30'd0, state},      0);
    chk("rst_score",  {16'd0, score},      0);
    chk("rst_balls",  {30'd0, balls_left}, 0);
    chk("rst_grant",  {28'd0, grant},      0);
    chk("rst_missed", {31'd0, missed},     0);

    // Single hit on requester 0
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_score", {16'd0, score}, 100);
    chk("t1_grant", {28'd0, grant}, 4'b0001);
    chk("t1_balls", {30'd0, balls_left}, 3);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_grant_off", {28'd0, grant}, 0);

    // All four at once: serviced in index order on consecutive cycles
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 4'b1111);
    cyc(1'b0, 1'b0, 1'b0, 4'd0); chk("t2_g0", {28'd0, grant}, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0, 4'd0); chk("t2_g1", {28'd0, grant}, 4'b0010);
    cyc(1'b0, 1'b0, 1'b0, 4'd0); chk("t2_g2", {28'd0, grant}, 4'b0100);
    cyc(1'b0, 1'b0, 1'b0, 4'd0); chk("t2_g3", {28'd0, grant}, 4'b1000);
    chk("t2_score", {16'd0, score}, 1850);

    // Repeat hit on a still-pending bit is merged and flagged
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0100);
    cyc(1'b0, 1'b0, 1'b0, 4'b0100);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t3_missed", {31'd0, missed}, 1);
    chk("t3_score",  {16'd0, score}, 850);

    // Saturation
    new_game();
    repeat (65) cyc(1'b0, 1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t4_score_65000", {16'd0, score}, 65000);
    chk("t4_no_miss", {31'd0, missed}, 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t4_score_sat", {16'd0, score}, 65535);
    chk("t4_grant", {28'd0, grant}, 4'b1000);

    // Ball drains, game over, frozen score, restart
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t5_balls3", {30'd0, balls_left}, 3);
    cyc(1'b0, 1'b0, 1'b1, 4'd0); chk("t5_balls2", {30'd0, balls_left}, 2);
    cyc(1'b0, 1'b0, 1'b1, 4'd0); chk("t5_balls1", {30'd0, balls_left}, 1);
    cyc(1'b0, 1'b0, 1'b1, 4'd0); chk("t5_over", {30'd0, state}, 2);
    cyc(1'b0, 1'b0, 1'b0, 4'b1111);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t5_frozen", {16'd0, score}, 100);
    chk("t5_no_grant", {28'd0, grant}, 0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    chk("t5_rs_score", {16'd0, score}, 0);
    chk("t5_rs_balls", {30'd0, balls_left}, 3);
    chk("t5_rs_state", {30'd0, state}, 1);

    // Drain coincident with a grant: add applied, rest abandoned
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 4'b1010);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("t6_score", {16'd0, score}, 250);
    chk("t6_grant", {28'd0, grant}, 4'b0010);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t6_grant_off", {28'd0, grant}, 0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t6_score_hold", {16'd0, score}, 250);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] q;
      for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 39) == 0, q);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pinball_score_ctrl.md
PINBALL_SCORE_CTRL -- requirements
Module: pinball_score_ctrl

Interface
REQ-001 SHALL have parameter PV0, default 100, points for requester 0.
REQ-002 SHALL have parameter PV1, default 250, points for requester 1.
REQ-003 SHALL have parameter PV2, default 500, points for requester 2.
REQ-004 SHALL have parameter PV3, default 1000, points for requester 3.
REQ-005 SHALL have parameter BALLS, default 3, balls per game (1..3).
REQ-006 SHALL have port MAX10_CLK1_50  input  1  system clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  single-cycle new-game pulse.
REQ-009 SHALL have port drain  input  1  single-cycle ball-lost pulse.
REQ-010 SHALL have port req  input  4  single-cycle scoring pulses, one per requester (bumpers/targets).
REQ-011 SHALL have port score  output  16  current game score, unsigned binary.
REQ-012 SHALL have port grant  output  4  one-hot, high for one cycle when a requester's points are added.
REQ-013 SHALL have port balls_left  output  2  balls remaining in current game.
REQ-014 SHALL have port state  output  2  game state: 0 IDLE, 1 PLAY, 2 OVER.
REQ-015 SHALL have port missed  output  1  sticky flag, a hit merged into an already-pending request.

Function
REQ-016 SHALL implement FSM IDLE -> PLAY on start; PLAY -> OVER on drain when balls_left==1; OVER -> PLAY on start; encoding 3 unused and recovers to IDLE next edge.
REQ-017 SHALL, on start in IDLE or OVER: score<=0, balls_left<=BALLS, pend<=0, rr<=0, missed<=0, state<=PLAY.
REQ-018 SHALL ignore start while in PLAY.
REQ-019 SHALL, on drain in PLAY with balls_left>1, decrement balls_left, clear pend, stay PLAY.
REQ-020 SHALL ignore drain outside PLAY.
REQ-021 SHALL, in PLAY only, capture each req bit into a 4-bit pending register at the edge it is sampled high; req outside PLAY discarded.
REQ-022 SHALL set missed when a req bit is sampled high while the same pend bit is already set and not being granted that edge; the hit counts once.
REQ-023 SHALL, at each PLAY edge with pend!=0, select exactly one pend bit round-robin: first set bit at index rr, rr+1, ... mod 4.
REQ-024 SHALL, on selection of index i, add PVi to score, clear pend[i] (unless req[i] high same edge, which re-sets it), drive grant=1<<i for the following cycle, set rr<=(i+1) mod 4.
REQ-025 SHALL saturate score at 65535 (17-bit sum, clamp); grant still pulses.
REQ-026 SHALL hold grant at 0 on any edge with no selection; at most one grant bit high at any time.
REQ-027 SHALL give latency: req sampled at edge k, no contention -> score and grant updated at edge k+1; worst case under full contention edge k+4.
REQ-028 SHALL, on drain and selection at the same edge, apply the score add first, then clear all pend bits (no further grants for that ball).
REQ-029 SHALL, on final drain, freeze score; score holds in OVER until next start.
REQ-030 SHALL keep score unchanged in IDLE and OVER.

Reset
REQ-031 SHALL, on rst high at an edge: state=IDLE, score=0, balls_left=0, pend=0, rr=0, grant=0, missed=0; rst overrides start, drain, req that edge.
REQ-032 SHALL, on rst mid-game, abandon all pending hits without adding points.

Verification
REQ-033 SHALL test: rst, start, req=4'b0001 one cycle -> next edge score=100, grant=0001 one cycle, balls_left=3.
REQ-034 SHALL test: in PLAY, req=4'b1111 one cycle -> grants 0001,0010,0100,1000 on four consecutive cycles, score=1850.
REQ-035 SHALL test: req[2] pulsed twice, one cycle apart, while pend[0],pend[1] pending from rr=0 -> missed=1, score gains 500 once.
REQ-036 SHALL test: score=65000, req[3] -> score=65535, grant=1000.
REQ-037 SHALL test: three drains -> balls_left 3,2,1 then state=OVER; req then ignored, score frozen; start -> score=0, balls_left=3, state=PLAY.
REQ-038 SHALL test: drain coincident with grant of req[1] and pend[3] set -> score +250 only, pend=0, grant=0010 then 0.
